lut_wvf_monitor: RTL

Receiving end of the LUT waveform generator stream. Consumes LUT_VALUE, LUT_END and the sample strobe (the same trigger that advances the generator). Aligns to the first period boundary, then accumulates per-period statistics: clock-cycle length, sample count, min, max and sum. Publishes one result record per period over a valid/ready handshake. Sits between the DDS output and the on-chip logging/readout path, and doubles as a self-check in generator benches.

---
 rtl/lut_wvf_monitor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lut_wvf_monitor.sv
// Per-period statistics monitor for the LUT waveform stream: aligns to LUT_END
// rising edges and publishes cycle length, sample count, min, max and sum per period.
module lut_wvf_monitor #(
  parameter int BITWIDTH   = 8,
  parameter int SMPL_CNT_W = 10,
  parameter int CYC_CNT_W  = 24
) (
  input  logic                           CLK_SYS,
  input  logic                           nRST,
  input  logic                           EN,
  input  logic                           SMPL_STRB,
  input  logic [BITWIDTH-1:0]            LUT_VALUE,
  input  logic                           LUT_END,
  input  logic                           RSLT_RDY,
  output logic                           RSLT_VLD,
  output logic [CYC_CNT_W-1:0]           PER_CYC,
  output logic [SMPL_CNT_W-1:0]          PER_SMPL,
  output logic [BITWIDTH-1:0]            VAL_MIN,
  output logic [BITWIDTH-1:0]            VAL_MAX,
  output logic [BITWIDTH+SMPL_CNT_W-1:0] VAL_SUM,
  output logic                           CYC_SAT,
  output logic                           OVRN,
  output logic [1:0]                     DBG_STATE
);

  localparam int SUM_W = BITWIDTH + SMPL_CNT_W;
  localparam logic [CYC_CNT_W-1:0]  CYC_MAX  = '1;
  localparam logic [CYC_CNT_W-1:0]  CYC_ONE  = CYC_CNT_W'(1);
  localparam logic [SMPL_CNT_W-1:0] SMPL_MAX = '1;
  localparam logic [SMPL_CNT_W-1:0] SMPL_ONE = SMPL_CNT_W'(1);
  localparam logic [BITWIDTH-1:0]   VAL_ONES = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, ACQ = 2'd2} state_t;

  // Handshake: a record transfers on any rising edge where RSLT_VLD and RSLT_RDY
  // are both high; the record is held stable while RSLT_VLD=1 and RSLT_RDY=0.
  state_t                  state_q, state_d;
  logic                    end_q, end_d;
  logic [CYC_CNT_W-1:0]    cyc_q, cyc_d, cyc_nx;
  logic                    sat_q, sat_d, sat_nx;
  logic [SMPL_CNT_W-1:0]   smpl_q, smpl_d, smpl_nx;
  logic [SUM_W-1:0]        sum_q, sum_d, sum_nx;
  logic [BITWIDTH-1:0]     min_q, min_d, min_nx;
  logic [BITWIDTH-1:0]     max_q, max_d, max_nx;
  logic                    vld_q, vld_d;
  logic [CYC_CNT_W-1:0]    per_cyc_q, per_cyc_d;
  logic [SMPL_CNT_W-1:0]   per_smpl_q, per_smpl_d;
  logic [BITWIDTH-1:0]     rmin_q, rmin_d;
  logic [BITWIDTH-1:0]     rmax_q, rmax_d;
  logic [SUM_W-1:0]        rsum_q, rsum_d;
  logic                    rsat_q, rsat_d;
  logic                    ovrn_q, ovrn_d;
  logic                    bnd, take, slot_free;

  always_comb begin
    bnd       = LUT_END & ~end_q;
    // A saturated sample count freezes sum and min/max as well.
    take      = SMPL_STRB & (smpl_q != SMPL_MAX);
    smpl_nx   = take ? smpl_q + SMPL_ONE : smpl_q;
    sum_nx    = take ? sum_q + SUM_W'(LUT_VALUE) : sum_q;
    min_nx    = (take && (LUT_VALUE < min_q)) ? LUT_VALUE : min_q;
    max_nx    = (take && (LUT_VALUE > max_q)) ? LUT_VALUE : max_q;
    if (cyc_q == CYC_MAX) begin
      cyc_nx = cyc_q;
      sat_nx = 1'b1;
    end else begin
      cyc_nx = cyc_q + CYC_ONE;
      sat_nx = sat_q;
    end
    slot_free = ~vld_q | RSLT_RDY;

    state_d    = state_q;
    end_d      = LUT_END;
    cyc_d      = cyc_q;
    sat_d      = sat_q;
    smpl_d     = smpl_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    vld_d      = vld_q & ~RSLT_RDY;
    per_cyc_d  = per_cyc_q;
    per_smpl_d = per_smpl_q;
    rmin_d     = rmin_q;
    rmax_d     = rmax_q;
    rsum_d     = rsum_q;
    rsat_d     = rsat_q;
    ovrn_d     = ovrn_q;

    if (!EN) begin
      state_d = IDLE;
      cyc_d   = '0;
      sat_d   = 1'b0;
      smpl_d  = '0;
      sum_d   = '0;
      min_d   = VAL_ONES;
      max_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (bnd) begin
            state_d = ACQ;
            cyc_d   = CYC_ONE;
            sat_d   = 1'b0;
            smpl_d  = '0;
            sum_d   = '0;
            min_d   = VAL_ONES;
            max_d   = '0;
          end
        end
        ACQ: begin
          if (bnd) begin
            // The strobe coincident with the boundary closes the ending period.
            if (slot_free) begin
              vld_d      = 1'b1;
              per_cyc_d  = cyc_q;
              per_smpl_d = smpl_nx;
              rmin_d     = (smpl_nx == '0) ? '0 : min_nx;
              rmax_d     = max_nx;
              rsum_d     = sum_nx;
              rsat_d     = sat_q;
            end else begin
              ovrn_d = 1'b1;
            end
            cyc_d  = CYC_ONE;
            sat_d  = 1'b0;
            smpl_d = '0;
            sum_d  = '0;
            min_d  = VAL_ONES;
            max_d  = '0;
          end else begin
            cyc_d  = cyc_nx;
            sat_d  = sat_nx;
            smpl_d = smpl_nx;
            sum_d  = sum_nx;
            min_d  = min_nx;
            max_d  = max_nx;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_SYS or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      end_q      <= 1'b0;
      cyc_q      <= '0;
      sat_q      <= 1'b0;
      smpl_q     <= '0;
      sum_q      <= '0;
      min_q      <= VAL_ONES;
      max_q      <= '0;
      vld_q      <= 1'b0;
      per_cyc_q  <= '0;
      per_smpl_q <= '0;
      rmin_q     <= '0;
      rmax_q     <= '0;
      rsum_q     <= '0;
      rsat_q     <= 1'b0;
      ovrn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      end_q      <= end_d;
      cyc_q      <= cyc_d;
      sat_q      <= sat_d;
      smpl_q     <= smpl_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
      vld_q      <= vld_d;
      per_cyc_q  <= per_cyc_d;
      per_smpl_q <= per_smpl_d;
      rmin_q     <= rmin_d;
      rmax_q     <= rmax_d;
      rsum_q     <= rsum_d;
      rsat_q     <= rsat_d;
      ovrn_q     <= ovrn_d;
    end
  end

  assign RSLT_VLD  = vld_q;
  assign PER_CYC   = per_cyc_q;
  assign PER_SMPL  = per_smpl_q;
  assign VAL_MIN   = rmin_q;
  assign VAL_MAX   = rmax_q;
  assign VAL_SUM   = rsum_q;
  assign CYC_SAT   = rsat_q;
  assign OVRN      = ovrn_q;
  assign DBG_STATE = state_q;

endmodule
